// File: rtl/spi_cs.sv
// SPI master with automatic chip-select framing of multi-byte bursts.
// A byte engine shifts MOSI/MISO MSB first; a three-state controller owns CS_n.
module spi_cs #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BYTES_PER_CS  = 2,
  parameter int CS_INACTIVE_CLKS  = 1,
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          system_clk,
  input  logic          reset,
  input  logic [CW-1:0] i_TX_Count,
  input  logic [7:0]    TX_Byte,
  input  logic          TX_valid,
  output logic          TX_start,
  output logic [CW-1:0] o_RX_Count,
  output logic          RX_valid,
  output logic [7:0]    RX_Byte,
  output logic          SPI_Clk,
  input  logic          SPI_MISO,
  output logic          SPI_MOSI,
  output logic          o_SPI_CS_n
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  localparam int HW = $clog2(2 * CLKS_PER_HALF_BIT);
  localparam logic [HW-1:0] C_HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [HW-1:0] C_FULL_LAST = HW'(2 * CLKS_PER_HALF_BIT - 1);

  localparam int IW = (CS_INACTIVE_CLKS > 0) ? $clog2(CS_INACTIVE_CLKS + 1) : 1;

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_TRANSFER    = 2'd1;
  localparam logic [1:0] S_CS_INACTIVE = 2'd2;

  // Burst controller
  logic [1:0]    r_state;
  logic          r_cs_n;
  logic [CW-1:0] r_remaining;
  logic [IW-1:0] r_inact_cnt;
  logic [CW-1:0] r_rx_count;

  // Byte engine
  logic          r_busy;
  logic          r_spi_clk;
  logic          r_leading;
  logic          r_trailing;
  logic [4:0]    r_edge_cnt;
  logic [HW-1:0] r_half_cnt;
  logic [7:0]    r_tx_byte;
  logic [2:0]    r_tx_bit;
  logic          r_mosi;
  logic [6:0]    r_rx_shift;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_byte;
  logic          r_rx_valid;

  logic          w_can_accept;
  logic          w_accept;
  logic          w_tx_shift;
  logic          w_rx_sample;
  logic          w_rx_done;
  logic          w_cs_release;

  // A request is taken only when the controller can start a byte; TX_start
  // advertises that opportunity while no request is pending.
  assign w_can_accept = reset &&
                        ((r_state == S_IDLE) ||
                         ((r_state == S_TRANSFER) && !r_busy && (r_remaining != '0)));
  assign w_accept     = w_can_accept && TX_valid;
  assign TX_start     = w_can_accept && !TX_valid;

  assign w_cs_release = (r_state == S_TRANSFER) && !r_busy && (r_remaining == '0);
  assign w_tx_shift   = CPHA ? r_leading : r_trailing;
  assign w_rx_sample  = CPHA ? r_trailing : r_leading;
  assign w_rx_done    = w_rx_sample && (r_rx_bit == 3'd0);

  // NOTE: every flop below uses non-blocking assignment so all registers see
  // pre-edge values; the reset branch is synchronous and clears every register.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cs_n      <= 1'b1;
      r_remaining <= '0;
      r_inact_cnt <= '0;
      r_rx_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (TX_valid) begin
            r_cs_n      <= 1'b0;
            r_remaining <= (i_TX_Count == '0) ? '0 : i_TX_Count - CW'(1);
            r_state     <= S_TRANSFER;
          end
        end
        S_TRANSFER: begin
          if (w_cs_release) begin
            r_cs_n      <= 1'b1;
            r_inact_cnt <= IW'(CS_INACTIVE_CLKS);
            r_state     <= S_CS_INACTIVE;
          end else if (w_accept) begin
            r_remaining <= r_remaining - CW'(1);
          end
        end
        S_CS_INACTIVE: begin
          if (r_inact_cnt == '0) r_state <= S_IDLE;
          else                   r_inact_cnt <= r_inact_cnt - IW'(1);
        end
        default: r_state <= S_IDLE;
      endcase

      // Cleared on the same edge CS_n rises so the count is 0 whenever CS_n is high.
      if (r_cs_n || w_cs_release)
        r_rx_count <= '0;
      else if (w_rx_done && (r_rx_count != CW'(MAX_BYTES_PER_CS)))
        r_rx_count <= r_rx_count + CW'(1);
    end
  end

  // 16 SPI_Clk edges per byte, one every CLKS_PER_HALF_BIT system clocks.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_spi_clk  <= CPOL;
      r_leading  <= 1'b0;
      r_trailing <= 1'b0;
      r_edge_cnt <= '0;
      r_half_cnt <= '0;
    end else begin
      r_leading  <= 1'b0;
      r_trailing <= 1'b0;
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_edge_cnt <= 5'd16;
        r_half_cnt <= '0;
      end else if (r_edge_cnt != '0) begin
        r_busy <= 1'b1;
        if (r_half_cnt == C_FULL_LAST) begin
          r_edge_cnt <= r_edge_cnt - 5'd1;
          r_trailing <= 1'b1;
          r_half_cnt <= '0;
          r_spi_clk  <= ~r_spi_clk;
        end else if (r_half_cnt == C_HALF_LAST) begin
          r_edge_cnt <= r_edge_cnt - 5'd1;
          r_leading  <= 1'b1;
          r_half_cnt <= r_half_cnt + HW'(1);
          r_spi_clk  <= ~r_spi_clk;
        end else begin
          r_half_cnt <= r_half_cnt + HW'(1);
        end
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  // With CPHA=0 bit 7 must be on MOSI before the first (sampling) edge.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      r_tx_byte <= '0;
      r_tx_bit  <= 3'd7;
      r_mosi    <= 1'b0;
    end else if (w_accept) begin
      r_tx_byte <= TX_Byte;
      if (!CPHA) begin
        r_mosi   <= TX_Byte[7];
        r_tx_bit <= 3'd6;
      end else begin
        r_tx_bit <= 3'd7;
      end
    end else if (w_tx_shift) begin
      r_mosi   <= r_tx_byte[r_tx_bit];
      r_tx_bit <= r_tx_bit - 3'd1;
    end
  end

  always_ff @(posedge system_clk) begin
    if (!reset) begin
      r_rx_shift <= '0;
      r_rx_bit   <= 3'd7;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_accept) begin
        r_rx_bit <= 3'd7;
      end else if (w_rx_sample) begin
        r_rx_shift <= {r_rx_shift[5:0], SPI_MISO};
        if (w_rx_done) begin
          r_rx_byte  <= {r_rx_shift, SPI_MISO};
          r_rx_valid <= 1'b1;
          r_rx_bit   <= 3'd7;
        end else begin
          r_rx_bit <= r_rx_bit - 3'd1;
        end
      end
    end
  end

  assign o_SPI_CS_n = r_cs_n;
  assign o_RX_Count = r_rx_count;
  assign RX_valid   = r_rx_valid;
  assign RX_Byte    = r_rx_byte;
  assign SPI_Clk    = r_spi_clk;
  assign SPI_MOSI   = r_mosi;

endmodule

// File: tb/tb_spi_cs.sv
// Self-checking bench for spi_cs: a mode-3 and a mode-0 instance in MOSI->MISO
// loopback, with expected receive bytes queued at send time and compared on RX_valid.
module tb_spi_cs;

  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;

  logic [CW-1:0] tx_count_3, rx_count_3, tx_count_0, rx_count_0;
  logic [7:0]    tx_byte_3, rx_byte_3, tx_byte_0, rx_byte_0;
  logic          tx_valid_3, tx_start_3, rx_valid_3, sclk_3, mosi_3, miso_3, cs_n_3;
  logic          tx_valid_0, tx_start_0, rx_valid_0, sclk_0, mosi_0, miso_0, cs_n_0;

  assign miso_3 = mosi_3;
  assign miso_0 = mosi_0;

  spi_cs #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(4), .MAX_BYTES_PER_CS(2), .CS_INACTIVE_CLKS(10)) dut_3 (
    .system_clk(clk), .reset(reset), .i_TX_Count(tx_count_3), .TX_Byte(tx_byte_3),
    .TX_valid(tx_valid_3), .TX_start(tx_start_3), .o_RX_Count(rx_count_3),
    .RX_valid(rx_valid_3), .RX_Byte(rx_byte_3), .SPI_Clk(sclk_3), .SPI_MISO(miso_3),
    .SPI_MOSI(mosi_3), .o_SPI_CS_n(cs_n_3));

  spi_cs #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2), .MAX_BYTES_PER_CS(2), .CS_INACTIVE_CLKS(1)) dut_0 (
    .system_clk(clk), .reset(reset), .i_TX_Count(tx_count_0), .TX_Byte(tx_byte_0),
    .TX_valid(tx_valid_0), .TX_start(tx_start_0), .o_RX_Count(rx_count_0),
    .RX_valid(rx_valid_0), .RX_Byte(rx_byte_0), .SPI_Clk(sclk_0), .SPI_MISO(miso_0),
    .SPI_MOSI(mosi_0), .o_SPI_CS_n(cs_n_0));

  typedef struct packed {
    logic [7:0]    b;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q3[$];
  exp_t q0[$];
  exp_t e3, e0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int rx_seen_3 = 0, rx_seen_0 = 0;
  int cs_falls_3 = 0, cs_falls_0 = 0;
  int cs_high_run3 = 0, cs_gap3 = 0;
  int inact_tx_start_3 = 0, cnt_not_clear = 0, rxv_long = 0, sclk0_idle_bad = 0;
  int rx_in_win0 = 0, last_win_rx0 = 0;
  int fall_t3[$];
  logic [7:0] mosi_bits0 = '0;
  int mosi_n0 = 0;
  logic prev_cs3 = 1'b1, prev_cs0 = 1'b1, prev_sclk3 = 1'b1, prev_sclk0 = 1'b0;
  logic prev_rxv3 = 1'b0, prev_rxv0 = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mode-3 monitor: scoreboard pop, CS window / gap bookkeeping, SPI_Clk falls.
  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid_3) begin
        rx_seen_3++;
        check("rx3_expected_pending", 32'(q3.size() != 0), 1);
        if (q3.size() != 0) begin
          e3 = q3.pop_front();
          check("rx3_byte", rx_byte_3, e3.b);
          check("rx3_count", rx_count_3, e3.cnt);
        end
      end
      if (!cs_n_3 && prev_cs3) begin
        cs_falls_3++;
        cs_gap3 = cs_high_run3;
      end
      cs_high_run3 = cs_n_3 ? cs_high_run3 + 1 : 0;
      if (cs_n_3 && cs_falls_3 > 0 && cs_high_run3 <= 10 && tx_start_3) inact_tx_start_3++;
      if (cs_n_3 && rx_count_3 != '0) cnt_not_clear++;
      if (!sclk_3 && prev_sclk3) fall_t3.push_back(cyc);
      if (rx_valid_3 && prev_rxv3) rxv_long++;
    end
    prev_cs3   = cs_n_3;
    prev_sclk3 = sclk_3;
    prev_rxv3  = rx_valid_3;
  end

  // Mode-0 monitor: scoreboard pop, MOSI captured at SPI_Clk rising edges.
  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid_0) begin
        rx_seen_0++;
        rx_in_win0++;
        check("rx0_expected_pending", 32'(q0.size() != 0), 1);
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          check("rx0_byte", rx_byte_0, e0.b);
          check("rx0_count", rx_count_0, e0.cnt);
        end
      end
      if (!cs_n_0 && prev_cs0) begin
        cs_falls_0++;
        rx_in_win0 = 0;
      end
      if (cs_n_0 && !prev_cs0) last_win_rx0 = rx_in_win0;
      if (sclk_0 && !prev_sclk0 && !cs_n_0) begin
        mosi_bits0 = {mosi_bits0[6:0], mosi_0};
        mosi_n0++;
      end
      if (cs_n_0 && sclk_0 !== 1'b0) sclk0_idle_bad++;
      if (cs_n_0 && rx_count_0 != '0) cnt_not_clear++;
      if (rx_valid_0 && prev_rxv0) rxv_long++;
    end
    prev_cs0   = cs_n_0;
    prev_sclk0 = sclk_0;
    prev_rxv0  = rx_valid_0;
  end

  task automatic send3(input logic [7:0] b, input logic [CW-1:0] idx);
    int n = 0;
    while (!tx_start_3 && n < 1000) begin @(negedge clk); n++; end
    check("send3_ready", tx_start_3, 1);
    tx_byte_3 = b; tx_valid_3 = 1'b1;
    q3.push_back(exp_t'{b, idx});
    @(negedge clk); tx_valid_3 = 1'b0;
  endtask

  task automatic send0(input logic [7:0] b, input logic [CW-1:0] idx, input bit expect_it);
    int n = 0;
    while (!tx_start_0 && n < 1000) begin @(negedge clk); n++; end
    check("send0_ready", tx_start_0, 1);
    tx_byte_0 = b; tx_valid_0 = 1'b1;
    if (expect_it) q0.push_back(exp_t'{b, idx});
    @(negedge clk); tx_valid_0 = 1'b0;
  endtask

  task automatic pulse3(input logic [7:0] b);
    tx_byte_3 = b; tx_valid_3 = 1'b1;
    @(negedge clk); tx_valid_3 = 1'b0;
  endtask

  task automatic wait_rx(input bit which0, input int n);
    int k = 0;
    while (((which0 ? rx_seen_0 : rx_seen_3) < n) && k < 2000) begin @(negedge clk); k++; end
    check(which0 ? "wait_rx0" : "wait_rx3", 32'((which0 ? rx_seen_0 : rx_seen_3) >= n), 1);
  endtask

  task automatic wait_cs_high(input bit which0);
    int k = 0;
    while (!(which0 ? cs_n_0 : cs_n_3) && k < 500) begin @(negedge clk); k++; end
    check(which0 ? "wait_cs_high0" : "wait_cs_high3", which0 ? cs_n_0 : cs_n_3, 1);
  endtask

  initial begin
    tx_count_3 = 2'd2; tx_byte_3 = '0; tx_valid_3 = 1'b0;
    tx_count_0 = 2'd1; tx_byte_0 = '0; tx_valid_0 = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cs3",      cs_n_3, 1);
    check("rst_sclk3",    sclk_3, 1);
    check("rst_mosi3",    mosi_3, 0);
    check("rst_rxv3",     rx_valid_3, 0);
    check("rst_rxbyte3",  rx_byte_3, 0);
    check("rst_rxcnt3",   rx_count_3, 0);
    check("rst_txstart3", tx_start_3, 0);
    check("rst_cs0",      cs_n_0, 1);
    check("rst_sclk0",    sclk_0, 0);

    reset = 1'b1;
    @(negedge clk);
    check("txstart3_after_reset", tx_start_3, 1);
    check("txstart0_after_reset", tx_start_0, 1);

    // Mode 3 burst of two: one CS window, 8-clock SPI_Clk period.
    send3(8'hC1, 2'd1);
    send3(8'hC2, 2'd2);
    wait_rx(1'b0, 2);
    wait_cs_high(1'b0);
    check("cs3_windows_burst1", cs_falls_3, 1);
    check("sclk3_period", (fall_t3.size() >= 2) ? fall_t3[1] - fall_t3[0] : 0, 8);

    // Second burst with ignored requests mid-byte and during CS_INACTIVE.
    send3(8'hA1, 2'd1);
    repeat (10) @(negedge clk);
    pulse3(8'hEE);
    send3(8'hB2, 2'd2);
    wait_rx(1'b0, 4);
    wait_cs_high(1'b0);
    pulse3(8'hDD);
    repeat (30) @(negedge clk);
    check("rx3_total",           rx_seen_3, 4);
    check("rx3_queue_drained",   q3.size(), 0);
    check("cs3_windows_total",   cs_falls_3, 2);
    check("cs3_gap_ge_10",       32'(cs_gap3 >= 10), 1);
    check("txstart3_inactive",   inact_tx_start_3, 0);

    // Mode 0 single byte: idle-low clock, MOSI MSB first on rising edges.
    send0(8'h5A, 2'd1, 1'b1);
    wait_rx(1'b1, 1);
    wait_cs_high(1'b1);
    check("mosi0_bits",      mosi_bits0, 8'h5A);
    check("mosi0_rises",     mosi_n0, 8);
    check("sclk0_idle_low",  sclk_0, 0);

    // Count of 0 behaves as one byte per CS window.
    tx_count_0 = 2'd0;
    send0(8'h3C, 2'd1, 1'b1);
    wait_rx(1'b1, 2);
    wait_cs_high(1'b1);
    repeat (20) @(negedge clk);
    check("cnt0_window_bytes", last_win_rx0, 1);
    check("cnt0_windows",      cs_falls_0, 2);
    check("cnt0_cs_high",      cs_n_0, 1);

    // Reset mid-byte aborts with no late RX_valid.
    tx_count_0 = 2'd1;
    send0(8'h77, 2'd1, 1'b0);
    repeat (8) @(negedge clk);
    check("midbyte_cs_low", cs_n_0, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_cs0",      cs_n_0, 1);
    check("abort_sclk0",    sclk_0, 0);
    check("abort_rxv0",     rx_valid_0, 0);
    check("abort_rxcnt0",   rx_count_0, 0);
    check("abort_txstart0", tx_start_0, 0);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_rx",     rx_seen_0, 2);
    check("abort_cs0_idle",  cs_n_0, 1);

    check("rx_count_clear_when_cs_high", cnt_not_clear, 0);
    check("rx_valid_single_cycle",       rxv_long, 0);
    check("sclk0_idle_when_cs_high",     sclk0_idle_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
